mainfsm_ws: RTL
===============

Name: mainfsm_ws

Overview:
- Parametrised successor to the multicycle main controller FSM.
- Adds three things:
  - memory wait-state handshake (MemReq/MemReady) with a bounded timeout and a sticky fault;
  - a multi-cycle multiply execute path with configurable latency;
  - an undefined-instruction pulse that recovers to FETCH instead of hanging.
- Sits in the controller between the decoder and the datapath, driving the same datapath control set as before plus the new handshake and status outputs.

Parameters:
- WAIT_MAX, 15: maximum consecutive MemReady-low cycles tolerated per memory state; 0 disables the timeout (wait forever).
- MUL_LAT, 4: cycles spent in EXECUTEM, ≥1.
- CNT_W, 8: width of the shared wait/latency counter. WAIT_MAX and MUL_LAT must each be < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Op  in  2  instruction op field.
- Funct  in  6  instruction funct field.
- IsMul  in  1  decoder flag: current instruction is a multiply (valid in DECODE).
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- MemReq  out  1  memory access request.
- MulStart  out  1  one-cycle multiplier start pulse.
- Undef  out  1  one-cycle undefined-instruction pulse.
- Fault  out  1  sticky memory-timeout fault.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNDEF=10, EXECUTEM=11, FAULT=12. Any other value goes to FETCH.
- Reset (reset=0):
  - state=FETCH, cnt=0, mul_wb=0, Fault=0;
  - IRWrite, NextPC, RegW, MemW, Branch, MemReq, MulStart and Undef are forced 0 while reset is low;
  - the mux selects show their FETCH values.
- Transitions:
  - FETCH → DECODE when MemReady=1, else stay in FETCH.
  - DECODE:
    - Op=00 & IsMul → EXECUTEM;
    - Op=00 & Funct[5] → EXECUTEI;
    - Op=00 otherwise → EXECUTER;
    - Op=01 → MEMADR;
    - Op=10 → BRANCH;
    - Op=11 → UNDEF.
  - MEMADR → MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD → MEMWB on MemReady, else stay.
  - MEMWR → FETCH on MemReady, else stay.
  - EXECUTER and EXECUTEI → ALUWB.
  - EXECUTEM → ALUWB after exactly MUL_LAT cycles in the state.
  - ALUWB, MEMWB, BRANCH and UNDEF → FETCH.
  - FAULT → FAULT until reset.
- Counter cnt (CNT_W bits):
  - cleared on entry to FETCH, MEMRD, MEMWR and EXECUTEM;
  - in a memory state, increments each cycle MemReady=0;
  - in EXECUTEM, increments every cycle, and the exit is taken when cnt==MUL_LAT-1.
- Timeout (WAIT_MAX≠0): in FETCH, MEMRD or MEMWR, with MemReady=0 and cnt==WAIT_MAX, the next state is FAULT.
  - Ready on wait cycle index WAIT_MAX (0-based) still completes normally.
  - Fault=1 from entry to FAULT until reset.
- Outputs per state (unlisted outputs are 0):
  - FETCH: MemReq=1, ResultSrc=10, ALUSrcA=01, ALUSrcB=10. IRWrite=NextPC=MemReady, so the IR and PC update only on the completing cycle.
  - DECODE: ResultSrc=10, ALUSrcA=01, ALUSrcB=10.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - EXECUTEM: MulStart=1 on the first cycle only (cnt==0).
  - ALUWB: RegW=1, ResultSrc = 11 if mul_wb else 00.
  - MEMADR: ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1.
  - MEMWB: RegW=1, ResultSrc=01.
  - MEMWR: MemReq=1, AdrSrc=1, MemW=1 held for the whole wait; memory commits on the MemReady cycle.
  - BRANCH: Branch=1, ResultSrc=10, ALUSrcA=10, ALUSrcB=01.
  - UNDEF: Undef=1.
  - FAULT: all enables 0, Fault=1.
- mul_wb is set when entering EXECUTEM and cleared when leaving ALUWB.
- Asynchronous reset mid-wait or mid-multiply returns immediately to FETCH with cnt=0, Fault=0 and no partial writes.

Test Plan:
- Data-processing register instruction, MemReady=1 always: state sequence 0,1,6,8,0. IRWrite=1 in FETCH only. RegW=1 in ALUWB with ResultSrc=00.
- Load, Op=01, Funct[0]=1, MemReady low for 3 cycles in both FETCH and MEMRD: FETCH lasts 4 cycles with IRWrite=1 only on the 4th. MEMRD lasts 4 cycles. MEMWB asserts RegW=1 with ResultSrc=01.
- Store, Op=01, Funct[0]=0, WAIT_MAX=15, MemReady held low: MEMWR holds MemW=1 for 16 cycles, then enters FAULT (State=12, Fault=1) and stays there. Asserting reset=0 clears Fault and returns to FETCH.
- Multiply with IsMul=1, MUL_LAT=4: EXECUTEM lasts exactly 4 cycles. MulStart is high on the first only. ALUWB drives ResultSrc=11 and RegW=1; the next ALU instruction uses ResultSrc=00.
- Op=11: one UNDEF cycle with Undef=1, then FETCH. Op=10: BRANCH with Branch=1, ALUSrcA=10, ALUSrcB=01, then FETCH.
- Reset asserted for 2 cycles during EXECUTEM, and again during a FETCH wait: State=0 immediately, with MemReq, MulStart, IRWrite, NextPC and RegW all 0 while reset is low. Normal FETCH resumes after release.

Source files
------------

// File: rtl/mainfsm_ws.sv
// Multicycle main controller with memory wait-state handshake, bounded wait
// timeout (sticky fault), multi-cycle multiply execute and undefined-op recovery.
//
// state    | meaning
// FETCH    | instruction fetch, waits on MemReady
// DECODE   | register read, dispatch on Op
// MEMADR   | address compute for load/store
// MEMRD    | data read, waits on MemReady
// MEMWB    | load writeback
// MEMWR    | data write, waits on MemReady
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | ALU/multiply writeback
// BRANCH   | branch target select
// UNDEF    | one-cycle undefined-instruction pulse
// EXECUTEM | multiply, MUL_LAT cycles
// FAULT    | memory timeout, held until reset
`timescale 1ns/1ps
module mainfsm_ws #(
  parameter int WAIT_MAX = 15,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MemReq,
  output logic       MulStart,
  output logic       Undef,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNDEF    = 4'd10,
    EXECUTEM = 4'd11,
    FAULT    = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_CMP = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] MUL_CMP  = CNT_W'(MUL_LAT - 1);
  localparam logic             TO_EN    = (WAIT_MAX != 0);

  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic             mul_wb;
  logic             fault_q;
  logic             mem_state;
  logic             timeout;
  logic             unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign mem_state    = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout      = TO_EN && !MemReady && (cnt == WAIT_CMP);

  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = MemReady ? DECODE : (timeout ? FAULT : FETCH);
      DECODE: begin
        case (Op)
          2'b00: begin
            if (IsMul)         next = EXECUTEM;
            else if (Funct[5]) next = EXECUTEI;
            else               next = EXECUTER;
          end
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: next = UNDEF;
        endcase
      end
      MEMADR:   next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next = MemReady ? MEMWB : (timeout ? FAULT : MEMRD);
      MEMWR:    next = MemReady ? FETCH : (timeout ? FAULT : MEMWR);
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      EXECUTEM: next = (cnt == MUL_CMP) ? ALUWB : EXECUTEM;
      ALUWB:    next = FETCH;
      MEMWB:    next = FETCH;
      BRANCH:   next = FETCH;
      UNDEF:    next = FETCH;
      FAULT:    next = FAULT;
      default:  next = FETCH;
    endcase
  end

  // Counter restarts on every state change; only wait and multiply states read it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      cnt     <= '0;
      mul_wb  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state <= next;
      if (next != state)
        cnt <= '0;
      else if ((state == EXECUTEM) || (mem_state && !MemReady))
        cnt <= cnt + CNT_W'(1);
      if ((next == EXECUTEM) && (state != EXECUTEM))
        mul_wb <= 1'b1;
      else if (state == ALUWB)
        mul_wb <= 1'b0;
      if (next == FAULT)
        fault_q <= 1'b1;
    end
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    MemReq    = 1'b0;
    MulStart  = 1'b0;
    Undef     = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
      end
      DECODE: begin
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      EXECUTEM: MulStart = (cnt == '0);
      ALUWB: begin
        RegW      = 1'b1;
        ResultSrc = mul_wb ? 2'b11 : 2'b00;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
      end
      MEMWR: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      BRANCH: begin
        Branch    = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
      end
      UNDEF:   Undef = 1'b1;
      default: ;
    endcase
    // Reset parks the state in FETCH; keep its request and write enables quiet.
    if (!reset) begin
      IRWrite  = 1'b0;
      NextPC   = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      Branch   = 1'b0;
      MemReq   = 1'b0;
      MulStart = 1'b0;
      Undef    = 1'b0;
    end
  end

  assign Fault = fault_q;
  assign State = state;

endmodule
